// File: rtl/zbb_iter_unit_pkg.sv
// Shared definitions for the iterative Zbb unit: op codes, FSM states and
// accumulator width.
package zbb_iter_unit_pkg;

  localparam int OP_W  = 3;
  localparam int ACC_W = 6;

  localparam logic [OP_W-1:0] OP_CLZ  = 3'd0;
  localparam logic [OP_W-1:0] OP_CTZ  = 3'd1;
  localparam logic [OP_W-1:0] OP_CPOP = 3'd2;
  localparam logic [OP_W-1:0] OP_ROL  = 3'd3;
  localparam logic [OP_W-1:0] OP_ROR  = 3'd4;
  localparam logic [OP_W-1:0] OP_RORI = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Count ops walk the operand a slice at a time for a fixed number of steps.
  function automatic logic op_is_scan(input logic [OP_W-1:0] op);
    return (op == OP_CLZ) || (op == OP_CTZ) || (op == OP_CPOP);
  endfunction

  function automatic logic op_is_rot(input logic [OP_W-1:0] op);
    return (op == OP_ROL) || (op == OP_ROR) || (op == OP_RORI);
  endfunction

endpackage

// File: rtl/zbb_iter_slice.sv
// Combinational per-slice statistics used by one scan step: population count,
// leading/trailing zero count and whether any bit is set.
module zbb_iter_slice #(
  parameter int W     = 4,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     slice_i,
  output logic [CNT_W-1:0] pop_o,
  output logic [CNT_W-1:0] lz_o,
  output logic [CNT_W-1:0] tz_o,
  output logic             any_o
);

  logic hit_lz;
  logic hit_tz;

  // Count ones and the zero runs from each end of the slice.
  always_comb begin
    pop_o  = '0;
    lz_o   = '0;
    tz_o   = '0;
    hit_lz = 1'b0;
    hit_tz = 1'b0;
    any_o  = |slice_i;
    for (int i = 0; i < W; i++) begin
      pop_o = pop_o + CNT_W'(slice_i[i]);
    end
    for (int i = W - 1; i >= 0; i--) begin
      if (slice_i[i]) hit_lz = 1'b1;
      else if (!hit_lz) lz_o = lz_o + CNT_W'(1);
    end
    for (int i = 0; i < W; i++) begin
      if (slice_i[i]) hit_tz = 1'b1;
      else if (!hit_tz) tz_o = tz_o + CNT_W'(1);
    end
  end

endmodule

// File: rtl/zbb_iter_unit.sv
// Iterative Zbb unit: CLZ/CTZ/CPOP scan BITS_PER_CYCLE bits per step, rotates
// move one bit position per step. Responds over a valid/ready pair.
module zbb_iter_unit
  import zbb_iter_unit_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 4,
  parameter int XLEN           = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [4:0]      req_imm,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_err,
  output logic            busy
);

  localparam int          CNT_W      = $clog2(BITS_PER_CYCLE + 1);
  localparam logic [5:0]  SCAN_STEPS = 6'(XLEN / BITS_PER_CYCLE);

  state_e                 state_q, state_d;
  logic [OP_W-1:0]        op_q, op_d;
  logic [XLEN-1:0]        work_q, work_d;
  logic [4:0]             shamt_q, shamt_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic                   seen_q, seen_d;
  logic [5:0]             cnt_q, cnt_d;
  logic [XLEN-1:0]        data_q, data_d;
  logic                   err_q, err_d;

  logic [BITS_PER_CYCLE-1:0] slice_in;
  logic [CNT_W-1:0]       sl_pop, sl_lz, sl_tz;
  logic                   sl_any;

  logic [XLEN-1:0]        work_step;
  logic [ACC_W-1:0]       acc_step;
  logic                   seen_step;
  logic [XLEN-1:0]        result_step;
  logic                   err_step;

  logic [4:0]             req_shamt;
  logic                   accept;
  logic                   unused_rs2;

  assign unused_rs2 = ^req_rs2[XLEN-1:5];

  // CLZ consumes the top slice and shifts left; CTZ/CPOP consume the bottom.
  assign slice_in = (op_q == OP_CLZ) ? work_q[XLEN-1 -: BITS_PER_CYCLE]
                                     : work_q[BITS_PER_CYCLE-1:0];

  zbb_iter_slice #(.W(BITS_PER_CYCLE), .CNT_W(CNT_W)) u_slice (
    .slice_i (slice_in),
    .pop_o   (sl_pop),
    .lz_o    (sl_lz),
    .tz_o    (sl_tz),
    .any_o   (sl_any)
  );

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = (state_q == S_DONE);
  assign resp_data  = data_q;
  assign resp_err   = err_q;

  assign req_shamt = (req_op == OP_RORI) ? req_imm : req_rs2[4:0];
  assign accept    = req_valid && req_ready && !flush;

  // One RUN step: advance the working register and accumulator.
  always_comb begin
    work_step   = work_q;
    acc_step    = acc_q;
    seen_step   = seen_q;
    result_step = '0;
    err_step    = 1'b0;
    case (op_q)
      OP_CLZ: begin
        work_step = work_q << BITS_PER_CYCLE;
        if (!seen_q)
          acc_step = acc_q + (sl_any ? ACC_W'(sl_lz) : ACC_W'(BITS_PER_CYCLE));
        seen_step   = seen_q | sl_any;
        result_step = XLEN'(acc_step);
      end
      OP_CTZ: begin
        work_step = work_q >> BITS_PER_CYCLE;
        if (!seen_q)
          acc_step = acc_q + (sl_any ? ACC_W'(sl_tz) : ACC_W'(BITS_PER_CYCLE));
        seen_step   = seen_q | sl_any;
        result_step = XLEN'(acc_step);
      end
      OP_CPOP: begin
        work_step   = work_q >> BITS_PER_CYCLE;
        acc_step    = acc_q + ACC_W'(sl_pop);
        result_step = XLEN'(acc_step);
      end
      OP_ROL: begin
        if (shamt_q != 5'd0) work_step = {work_q[XLEN-2:0], work_q[XLEN-1]};
        result_step = work_step;
      end
      OP_ROR, OP_RORI: begin
        if (shamt_q != 5'd0) work_step = {work_q[0], work_q[XLEN-1:1]};
        result_step = work_step;
      end
      default: begin
        err_step = 1'b1;
      end
    endcase
  end

  // FSM next state: accept in IDLE, step in RUN, hold result in DONE.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    work_d  = work_q;
    shamt_d = shamt_q;
    acc_d   = acc_q;
    seen_d  = seen_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_RUN;
          op_d    = req_op;
          work_d  = req_rs1;
          shamt_d = req_shamt;
          acc_d   = '0;
          seen_d  = 1'b0;
          if (op_is_scan(req_op))     cnt_d = SCAN_STEPS;
          else if (op_is_rot(req_op)) cnt_d = (req_shamt == 5'd0) ? 6'd1 : {1'b0, req_shamt};
          else                        cnt_d = 6'd1;
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          work_d = work_step;
          acc_d  = acc_step;
          seen_d = seen_step;
          cnt_d  = cnt_q - 6'd1;
          if (cnt_q == 6'd1) begin
            state_d = S_DONE;
            data_d  = result_step;
            err_d   = err_step;
          end
        end
      end
      S_DONE: begin
        if (flush || resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      work_q  <= '0;
      shamt_q <= '0;
      acc_q   <= '0;
      seen_q  <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      shamt_q <= shamt_d;
      acc_q   <= acc_d;
      seen_q  <= seen_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_zbb_iter_unit.sv
// Self-checking bench for zbb_iter_unit: directed scenarios plus randomized
// ops compared against an arithmetic reference model.
module tb_zbb_iter_unit;

  localparam int BPC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [4:0]  req_imm;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  zbb_iter_unit #(.BITS_PER_CYCLE(BPC), .XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_imm    (req_imm),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] a, input int s);
    if (s == 0) return a;
    return (a << s) | (a >> (32 - s));
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] a, input int s);
    if (s == 0) return a;
    return (a >> s) | (a << (32 - s));
  endfunction

  // Reference result: {err, data}.
  function automatic logic [32:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] imm);
    int n;
    n = 0;
    case (op)
      3'd0: begin
        for (int i = 31; i >= 0; i--) begin
          if (a[i]) break;
          n++;
        end
        return {1'b0, 32'(n)};
      end
      3'd1: begin
        for (int i = 0; i < 32; i++) begin
          if (a[i]) break;
          n++;
        end
        return {1'b0, 32'(n)};
      end
      3'd2:    return {1'b0, 32'($countones(a))};
      3'd3:    return {1'b0, rotl(a, int'(b % 32))};
      3'd4:    return {1'b0, rotr(a, int'(b % 32))};
      3'd5:    return {1'b0, rotr(a, int'(imm))};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] b, input logic [4:0] imm);
    int s;
    if (op <= 3'd2) return 32 / BPC;
    if (op == 3'd3 || op == 3'd4) s = int'(b % 32);
    else if (op == 3'd5) s = int'(imm);
    else return 1;
    return (s == 0) ? 1 : s;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] imm);
    req_valid = 1'b1;
    req_op    = op;
    req_rs1   = a;
    req_rs2   = b;
    req_imm   = imm;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Issue one op, check latency/result, and complete the handshake if resp_ready=1.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] imm);
    int lat;
    logic [32:0] exp;
    exp = ref_op(op, a, b, imm);
    chk({tag, ":ready"}, 32'(req_ready), 32'd1);
    issue(op, a, b, imm);
    chk({tag, ":busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (!resp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ":lat"}, 32'(lat), 32'(ref_lat(op, b, imm)));
    chk({tag, ":data"}, resp_data, exp[31:0]);
    chk({tag, ":err"}, 32'(resp_err), 32'(exp[32]));
    if (resp_ready) begin
      @(posedge clk); #1;
      chk({tag, ":idle"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] hold;
    logic        saw_valid;
    logic [2:0]  rop;
    logic [31:0] ra;

    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    req_op = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst:valid", 32'(resp_valid), 32'd0);
    chk("rst:data",  resp_data,       32'd0);
    chk("rst:err",   32'(resp_err),   32'd0);
    chk("rst:busy",  32'(busy),       32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst:ready", 32'(req_ready), 32'd1);

    // Count ops
    do_op("cpop1",   3'd2, 32'hF0F0_0001, 32'd0, 5'd0);
    do_op("clz1",    3'd0, 32'h0001_0000, 32'd0, 5'd0);
    do_op("clz0",    3'd0, 32'h0000_0000, 32'd0, 5'd0);
    do_op("ctz1",    3'd1, 32'h8000_0000, 32'd0, 5'd0);
    do_op("ctz0",    3'd1, 32'h0000_0000, 32'd0, 5'd0);
    do_op("cpop0",   3'd2, 32'h0000_0000, 32'd0, 5'd0);
    do_op("cpopall", 3'd2, 32'hFFFF_FFFF, 32'd0, 5'd0);

    // Rotates
    do_op("rol1",   3'd3, 32'h8000_0001, 32'd1,    5'd0);
    do_op("ror25",  3'd4, 32'h8000_0001, 32'h25,   5'd0);
    do_op("rori0",  3'd5, 32'h1234_5678, 32'd0,    5'd0);
    do_op("rol0",   3'd3, 32'hDEAD_BEEF, 32'h20,   5'd0);
    do_op("rori31", 3'd5, 32'h0000_0001, 32'd0,    5'd31);

    // Back-pressure in DONE, with a competing request held
    resp_ready = 1'b0;
    do_op("bp", 3'd1, 32'h0000_0100, 32'd0, 5'd0);
    hold = resp_data;
    req_valid = 1'b1; req_op = 3'd2; req_rs1 = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp:valid", 32'(resp_valid), 32'd1);
      chk("bp:data",  resp_data,       hold);
      chk("bp:ready", 32'(req_ready),  32'd0);
      chk("bp:busy",  32'(busy),       32'd1);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp:idle",   32'(busy),       32'd0);
    chk("bp:nvalid", 32'(resp_valid), 32'd0);
    do_op("bp2", 3'd2, 32'h0000_00FF, 32'd0, 5'd0);

    // Flush during RUN of CPOP, before step 3
    issue(3'd2, 32'hFFFF_0000, 32'd0, 5'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fl:busy",  32'(busy),       32'd0);
    chk("fl:valid", 32'(resp_valid), 32'd0);
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (resp_valid || busy) saw_valid = 1'b1;
    end
    chk("fl:quiet", 32'(saw_valid), 32'd0);

    // Request alongside flush in IDLE is dropped
    flush = 1'b1; req_valid = 1'b1; req_op = 3'd0; req_rs1 = 32'h1;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    chk("fl:noacc", 32'(busy), 32'd0);

    // Flush while holding a response in DONE
    resp_ready = 1'b0;
    do_op("fld", 3'd3, 32'h0000_0001, 32'd2, 5'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fld:idle", 32'(busy), 32'd0);
    resp_ready = 1'b1;
    do_op("flrec", 3'd0, 32'h0000_0F00, 32'd0, 5'd0);

    // Illegal op codes
    do_op("ill7", 3'd7, 32'hFFFF_FFFF, 32'd3, 5'd3);
    do_op("ill6", 3'd6, 32'h1234_5678, 32'd0, 5'd0);

    // Async reset mid-CLZ
    do_op("prerst", 3'd2, 32'h0000_0007, 32'd0, 5'd0);
    issue(3'd0, 32'h0000_0001, 32'd0, 5'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("arst:valid", 32'(resp_valid), 32'd0);
    chk("arst:busy",  32'(busy),       32'd0);
    chk("arst:data",  resp_data,       32'd0);
    chk("arst:err",   32'(resp_err),   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("arst:ready", 32'(req_ready), 32'd1);
    chk("arst:idle",  32'(busy),      32'd0);

    // Randomized ops against the reference model
    for (int n = 0; n < 60; n++) begin
      rop = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       ra = 32'h0;
        1:       ra = 32'h1 << $urandom_range(0, 31);
        default: ra = $urandom;
      endcase
      do_op("rand", rop, ra, $urandom, 5'($urandom_range(0, 31)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
